// File: rtl/tx_inband_pkg.sv
// Shared definitions for the inband TX buffer: header layout, packet size and router states.
package tx_inband_pkg;

    localparam int unsigned CHAN_W        = 5;
    localparam int unsigned CHAN_LSB      = 16;
    localparam int unsigned CHAN_MSB      = 20;
    localparam int unsigned PKT_WORDS_DEF = 128;

    localparam logic [CHAN_W-1:0] CMD_CHAN_ID = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FWD    = 2'd1,
        ST_DROP   = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/tx_packet_router_if.sv
// Word stream from tx_packer in, per-RAM write/commit strobes out.
interface tx_packet_router_if #(
    parameter int unsigned NUM_CHAN = 2
);
    logic [31:0]       usbdata_final;
    logic              WR_final;
    logic [NUM_CHAN:0] chan_have_space;
    logic [31:0]       ram_data;
    logic [NUM_CHAN:0] WR_channel;
    logic [NUM_CHAN:0] WR_done_channel;

    modport master (
        output usbdata_final, WR_final, chan_have_space,
        input  ram_data, WR_channel, WR_done_channel
    );

    modport slave (
        input  usbdata_final, WR_final, chan_have_space,
        output ram_data, WR_channel, WR_done_channel
    );
endinterface

// File: rtl/tx_route_decode.sv
// Maps a header channel code to a RAM index and decides whether the packet can be accepted.
module tx_route_decode #(
    parameter int unsigned                         NUM_CHAN    = 2,
    parameter logic [tx_inband_pkg::CHAN_W-1:0]    CMD_CHAN_ID = tx_inband_pkg::CMD_CHAN_ID,
    localparam int unsigned                        NR          = NUM_CHAN + 1,
    localparam int unsigned                        IW          = $clog2(NR)
) (
    input  logic [tx_inband_pkg::CHAN_W-1:0] chan_i,
    input  logic [NR-1:0]                    space_i,
    output logic [IW-1:0]                    dest_c_o,
    output logic                             accept_c_o
);
    import tx_inband_pkg::*;

    logic valid_c;

    // Command code wins; data channels are 0..NUM_CHAN-1; everything else is invalid.
    always_comb begin
        dest_c_o   = '0;
        valid_c    = 1'b0;
        accept_c_o = 1'b0;
        if (chan_i == CMD_CHAN_ID) begin
            dest_c_o = IW'(NUM_CHAN);
            valid_c  = 1'b1;
        end else if (32'(chan_i) < NUM_CHAN) begin
            dest_c_o = IW'(chan_i);
            valid_c  = 1'b1;
        end
        accept_c_o = valid_c & space_i[dest_c_o];
    end

endmodule

// File: rtl/tx_packet_router.sv
// Routes whole USB packets to channel/command RAMs; drops and counts unroutable packets.
module tx_packet_router #(
    parameter int unsigned                      NUM_CHAN    = 2,
    parameter int unsigned                      PKT_WORDS   = tx_inband_pkg::PKT_WORDS_DEF,
    parameter logic [tx_inband_pkg::CHAN_W-1:0] CMD_CHAN_ID = tx_inband_pkg::CMD_CHAN_ID,
    parameter int unsigned                      CNT_W       = 16
) (
    input  logic                              txclk,
    input  logic                              reset,
    tx_packet_router_if.slave                 bus,
    input  logic                              clear_status,
    output logic                              busy,
    output logic [tx_inband_pkg::CHAN_W-1:0]  cur_chan,
    output logic                              dropped,
    output logic [CNT_W-1:0]                  drop_count,
    output logic                              overrun
);
    import tx_inband_pkg::*;

    localparam int unsigned NR = NUM_CHAN + 1;
    localparam int unsigned IW = $clog2(NR);
    localparam int unsigned CW = $clog2(PKT_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(PKT_WORDS - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      dest_q, dest_d;
    logic [CHAN_W-1:0]  chan_q, chan_d;
    logic [31:0]        data_q, data_d;
    logic [NR-1:0]      wr_q, wr_d;
    logic [NR-1:0]      done_q, done_d;
    logic               busy_q, busy_d;
    logic               drop_q, drop_d;
    logic [CNT_W-1:0]   drops_q, drops_d;
    logic               ovr_q, ovr_d;

    logic [CHAN_W-1:0]  hdr_chan_c;
    logic [IW-1:0]      hdr_dest_c;
    logic               hdr_accept_c;
    logic               hdr_c;
    logic               ovr_set_c;
    logic               last_c;

    assign hdr_chan_c = bus.usbdata_final[CHAN_MSB:CHAN_LSB];

    tx_route_decode #(
        .NUM_CHAN    (NUM_CHAN),
        .CMD_CHAN_ID (CMD_CHAN_ID)
    ) u_decode (
        .chan_i     (hdr_chan_c),
        .space_i    (bus.chan_have_space),
        .dest_c_o   (hdr_dest_c),
        .accept_c_o (hdr_accept_c)
    );

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dest_q  <= '0;
            chan_q  <= '0;
            data_q  <= '0;
            wr_q    <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
            drops_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            chan_q  <= chan_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
            drops_q <= drops_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dest_d    = dest_q;
        chan_d    = chan_q;
        data_d    = data_q;
        wr_d      = '0;
        done_d    = '0;
        drop_d    = 1'b0;
        hdr_c     = 1'b0;
        ovr_set_c = 1'b0;
        last_c    = (cnt_q == LAST_IDX);

        case (state_q)
            ST_IDLE: hdr_c = bus.WR_final;
            ST_FWD: begin
                if (bus.WR_final) begin
                    data_d = bus.usbdata_final;
                    wr_d   = NR'(1) << dest_q;
                    if (last_c) state_d = ST_COMMIT;
                    else        cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_DROP: begin
                if (bus.WR_final) begin
                    if (last_c) begin
                        drop_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_COMMIT: begin
                // Commit the finished packet even if the next header lands this cycle.
                done_d    = NR'(1) << dest_q;
                state_d   = ST_IDLE;
                hdr_c     = bus.WR_final;
                ovr_set_c = bus.WR_final;
            end
            default: state_d = ST_IDLE;
        endcase

        if (hdr_c) begin
            cnt_d   = CW'(1);
            chan_d  = hdr_chan_c;
            dest_d  = hdr_dest_c;
            state_d = hdr_accept_c ? ST_FWD : ST_DROP;
            if (hdr_accept_c) begin
                data_d = bus.usbdata_final;
                wr_d   = NR'(1) << hdr_dest_c;
            end
        end

        busy_d = (state_d == ST_FWD) || (state_d == ST_DROP);

        // A clear coinciding with a drop keeps that drop.
        if (clear_status)                drops_d = CNT_W'(drop_d);
        else if (drop_d && !(&drops_q))  drops_d = drops_q + CNT_W'(1);
        else                             drops_d = drops_q;

        ovr_d = ovr_set_c | (ovr_q & ~clear_status);
    end

    assign bus.ram_data        = data_q;
    assign bus.WR_channel      = wr_q;
    assign bus.WR_done_channel = done_q;
    assign busy                = busy_q;
    assign cur_chan            = chan_q;
    assign dropped             = drop_q;
    assign drop_count          = drops_q;
    assign overrun             = ovr_q;

endmodule

// File: tb/tb_tx_packet_router.sv
// Randomized packet-level bench for tx_packet_router with a scoreboard of expected writes, commits and drops.
module tb_tx_packet_router;

    localparam int NCH = 2;
    localparam int PKT = 128;

    typedef struct { int stamp; int dest; logic [31:0] data; } wr_t;
    typedef struct { int stamp; int dest; } done_t;

    logic txclk;
    logic reset;
    logic clear_status;
    logic busy, busy2;
    logic [4:0] cur_chan, cur_chan2;
    logic dropped, dropped2;
    logic [15:0] drop_count;
    logic [1:0]  drop_count2;
    logic overrun, overrun2;

    tx_packet_router_if #(.NUM_CHAN(NCH)) bus ();
    tx_packet_router_if #(.NUM_CHAN(NCH)) bus2 ();

    assign bus2.usbdata_final   = bus.usbdata_final;
    assign bus2.WR_final        = bus.WR_final;
    assign bus2.chan_have_space = bus.chan_have_space;

    tx_packet_router #(.NUM_CHAN(NCH), .PKT_WORDS(PKT), .CMD_CHAN_ID(5'h1F), .CNT_W(16)) dut (
        .txclk(txclk), .reset(reset), .bus(bus.slave), .clear_status(clear_status),
        .busy(busy), .cur_chan(cur_chan), .dropped(dropped), .drop_count(drop_count), .overrun(overrun)
    );

    tx_packet_router #(.NUM_CHAN(NCH), .PKT_WORDS(PKT), .CMD_CHAN_ID(5'h1F), .CNT_W(2)) dut2 (
        .txclk(txclk), .reset(reset), .bus(bus2.slave), .clear_status(clear_status),
        .busy(busy2), .cur_chan(cur_chan2), .dropped(dropped2), .drop_count(drop_count2), .overrun(overrun2)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference model state (packet level)
    logic [2:0] space;
    int    widx = 0;
    int    pkt_dest = -1;
    int    last_fwd_edge = -100;
    int    drops = 0;
    bit    ovr_m = 0;
    wr_t   exp_wr[$];
    done_t exp_done[$];
    int    exp_drop[$];

    // Observed event counts and scoreboard status
    int    n_wr[3]   = '{0, 0, 0};
    int    n_done[3] = '{0, 0, 0};
    int    n_drop    = 0;
    int    stream_bad = 0;
    string bad_msg = "";

    initial begin
        txclk = 1'b0;
        forever #5 txclk = ~txclk;
    end

    always @(posedge txclk) cyc <= cyc + 1;

    always @(negedge txclk) begin
        wr_t t; done_t dn; int ds;
        if ($countones(bus.WR_channel) > 1 || $countones(bus.WR_done_channel) > 1) begin
            stream_bad++;
            if (bad_msg == "") bad_msg = $sformatf("non-onehot wr=%b done=%b at %0d", bus.WR_channel, bus.WR_done_channel, cyc);
        end
        for (int i = 0; i < 3; i++) begin
            if (bus.WR_channel[i]) begin
                n_wr[i]++;
                if (exp_wr.size() == 0) begin
                    stream_bad++;
                    if (bad_msg == "") bad_msg = $sformatf("unexpected write ch%0d at %0d", i, cyc);
                end else begin
                    t = exp_wr.pop_front();
                    if (t.stamp != cyc || t.dest != i || t.data !== bus.ram_data) begin
                        stream_bad++;
                        if (bad_msg == "") bad_msg = $sformatf("write got ch%0d %h @%0d want ch%0d %h @%0d",
                                                               i, bus.ram_data, cyc, t.dest, t.data, t.stamp);
                    end
                end
            end
            if (bus.WR_done_channel[i]) begin
                n_done[i]++;
                if (exp_done.size() == 0) begin
                    stream_bad++;
                    if (bad_msg == "") bad_msg = $sformatf("unexpected commit ch%0d at %0d", i, cyc);
                end else begin
                    dn = exp_done.pop_front();
                    if (dn.stamp != cyc || dn.dest != i) begin
                        stream_bad++;
                        if (bad_msg == "") bad_msg = $sformatf("commit got ch%0d @%0d want ch%0d @%0d", i, cyc, dn.dest, dn.stamp);
                    end
                end
            end
        end
        if (dropped) begin
            n_drop++;
            if (exp_drop.size() == 0) begin
                stream_bad++;
                if (bad_msg == "") bad_msg = $sformatf("unexpected drop at %0d", cyc);
            end else begin
                ds = exp_drop.pop_front();
                if (ds != cyc) begin
                    stream_bad++;
                    if (bad_msg == "") bad_msg = $sformatf("drop @%0d want @%0d", cyc, ds);
                end
            end
        end
    end

    function automatic int sat2(input int n);
        return (n > 3) ? 3 : n;
    endfunction

    function automatic logic [31:0] hdr_word(input int ch);
        logic [31:0] w;
        w = $urandom;
        w[20:16] = 5'(ch);
        return w;
    endfunction

    // One clock of stimulus; the model predicts what the edge taking this word must produce.
    task automatic drive(input bit we, input logic [31:0] w, input bit clr);
        int e, ch, d;
        bit dropped_now, set_ovr;
        bus.WR_final        = we;
        bus.usbdata_final   = we ? w : 32'h0;
        bus.chan_have_space = space;
        clear_status        = clr;
        e = cyc + 1;
        dropped_now = 0;
        set_ovr = 0;
        if (we) begin
            if (widx == 0) begin
                ch = int'(w[20:16]);
                d  = (ch == 31) ? NCH : ((ch < NCH) ? ch : -1);
                pkt_dest = (d >= 0 && space[d]) ? d : -1;
                set_ovr  = (e == last_fwd_edge + 1);
            end
            if (pkt_dest >= 0) exp_wr.push_back('{e, pkt_dest, w});
            widx++;
            if (widx == PKT) begin
                widx = 0;
                if (pkt_dest >= 0) begin
                    exp_done.push_back('{e + 1, pkt_dest});
                    last_fwd_edge = e;
                end else begin
                    exp_drop.push_back(e);
                    dropped_now = 1;
                end
            end
        end
        if (clr) drops = int'(dropped_now);
        else     drops = drops + int'(dropped_now);
        ovr_m = set_ovr | (ovr_m & !clr);
        @(posedge txclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 32'h0, 1'b0);
    endtask

    task automatic send_body(input int n, input int gap_pct);
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(99) < gap_pct) drive(1'b0, 32'h0, 1'b0);
            drive(1'b1, $urandom, 1'b0);
        end
    endtask

    task automatic send_pkt(input int ch, input int gap_pct);
        drive(1'b1, hdr_word(ch), 1'b0);
        send_body(PKT - 1, gap_pct);
    endtask

    task automatic model_reset();
        widx = 0;
        pkt_dest = -1;
        last_fwd_edge = -100;
        drops = 0;
        ovr_m = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.WR_final = 1'b0;
        bus.usbdata_final = 32'h0;
        space = 3'b111;
        bus.chan_have_space = space;
        clear_status = 1'b0;
        model_reset();
        repeat (2) @(posedge txclk);
        #1;
        checks++;
        if ({bus.ram_data, bus.WR_channel, bus.WR_done_channel} !== '0) begin
            fails++;
            $display("FAIL reset_bus: got data=%h wr=%b done=%b, want all 0", bus.ram_data, bus.WR_channel, bus.WR_done_channel);
        end
        checks++;
        if ({busy, cur_chan, dropped, drop_count, overrun, drop_count2} !== '0) begin
            fails++;
            $display("FAIL reset_status: got busy=%b chan=%0d drop=%b cnt=%0d ovr=%b cnt2=%0d, want all 0",
                     busy, cur_chan, dropped, drop_count, overrun, drop_count2);
        end
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_fwd_chan1();
        int w0, d0;
        w0 = n_wr[1];
        d0 = n_done[1];
        drive(1'b1, hdr_word(1), 1'b0);
        checks++;
        if (busy !== 1'b1 || cur_chan !== 5'd1) begin
            fails++;
            $display("FAIL fwd_busy: got busy=%b chan=%0d, want busy=1 chan=1", busy, cur_chan);
        end
        send_body(PKT - 1, 0);
        idle(3);
        checks++;
        if (n_wr[1] - w0 != PKT || n_done[1] - d0 != 1) begin
            fails++;
            $display("FAIL fwd_counts: got writes=%0d commits=%0d, want %0d and 1", n_wr[1] - w0, n_done[1] - d0, PKT);
        end
        checks++;
        if (stream_bad != 0 || exp_wr.size() != 0 || exp_done.size() != 0) begin
            fails++;
            $display("FAIL fwd_stream: got %0d errors (%s), pending wr=%0d done=%0d, want 0", stream_bad, bad_msg, exp_wr.size(), exp_done.size());
        end
        checks++;
        if (drop_count !== 16'(drops) || busy !== 1'b0) begin
            fails++;
            $display("FAIL fwd_status: got cnt=%0d busy=%b, want cnt=%0d busy=0", drop_count, busy, drops);
        end
    endtask

    task automatic test_cmd();
        int w0, w1, w2, d2;
        w0 = n_wr[0]; w1 = n_wr[1]; w2 = n_wr[2]; d2 = n_done[2];
        send_pkt(31, 0);
        idle(3);
        checks++;
        if (n_wr[2] - w2 != PKT || n_done[2] - d2 != 1 || n_wr[0] != w0 || n_wr[1] != w1) begin
            fails++;
            $display("FAIL cmd_route: got cmd writes=%0d commits=%0d other=%0d, want %0d, 1, 0",
                     n_wr[2] - w2, n_done[2] - d2, (n_wr[0] - w0) + (n_wr[1] - w1), PKT);
        end
        checks++;
        if (stream_bad != 0 || exp_wr.size() != 0 || exp_done.size() != 0) begin
            fails++;
            $display("FAIL cmd_stream: got %0d errors (%s), want 0", stream_bad, bad_msg);
        end
    endtask

    task automatic test_invalid_drop();
        int wt, dr0;
        wt  = n_wr[0] + n_wr[1] + n_wr[2];
        dr0 = n_drop;
        send_pkt(3, 0);
        send_pkt(7, 20);
        idle(2);
        checks++;
        if (n_drop - dr0 != 2 || (n_wr[0] + n_wr[1] + n_wr[2]) != wt) begin
            fails++;
            $display("FAIL invalid_drop: got drops=%0d writes=%0d, want 2 and 0", n_drop - dr0, n_wr[0] + n_wr[1] + n_wr[2] - wt);
        end
        checks++;
        if (drop_count !== 16'(drops) || drop_count2 !== 2'(sat2(drops)) || cur_chan !== 5'd7) begin
            fails++;
            $display("FAIL invalid_count: got cnt=%0d cnt2=%0d chan=%0d, want %0d %0d 7", drop_count, drop_count2, cur_chan, drops, sat2(drops));
        end
        drive(1'b0, 32'h0, 1'b1);
        checks++;
        if (drop_count !== 16'd0 || drop_count2 !== 2'd0) begin
            fails++;
            $display("FAIL clear_count: got cnt=%0d cnt2=%0d, want 0", drop_count, drop_count2);
        end
    endtask

    task automatic test_space();
        int w0, d0, dr0;
        w0 = n_wr[0]; d0 = n_done[0]; dr0 = n_drop;
        space = 3'b110;
        send_pkt(0, 0);
        space = 3'b111;
        drive(1'b1, hdr_word(0), 1'b0);
        send_body(9, 0);
        space = 3'b110;
        send_body(PKT - 10, 0);
        space = 3'b111;
        idle(3);
        checks++;
        if (n_drop - dr0 != 1 || drop_count !== 16'(drops)) begin
            fails++;
            $display("FAIL space_drop: got drops=%0d cnt=%0d, want 1 and %0d", n_drop - dr0, drop_count, drops);
        end
        checks++;
        if (n_wr[0] - w0 != PKT || n_done[0] - d0 != 1 || stream_bad != 0) begin
            fails++;
            $display("FAIL space_late: got writes=%0d commits=%0d errors=%0d (%s), want %0d 1 0",
                     n_wr[0] - w0, n_done[0] - d0, stream_bad, bad_msg, PKT);
        end
    endtask

    task automatic test_gaps_reset();
        int w0, d0, w1, d1;
        w0 = n_wr[0]; d0 = n_done[0];
        send_pkt(0, 50);
        idle(3);
        checks++;
        if (n_wr[0] - w0 != PKT || n_done[0] - d0 != 1 || stream_bad != 0) begin
            fails++;
            $display("FAIL gaps: got writes=%0d commits=%0d errors=%0d (%s), want %0d 1 0",
                     n_wr[0] - w0, n_done[0] - d0, stream_bad, bad_msg, PKT);
        end
        d0 = n_done[0];
        drive(1'b1, hdr_word(0), 1'b0);
        send_body(59, 50);
        idle(1);
        reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.ram_data, bus.WR_channel, bus.WR_done_channel, busy, cur_chan, dropped, drop_count, overrun} !== '0) begin
            fails++;
            $display("FAIL midreset_out: got data=%h wr=%b busy=%b chan=%0d cnt=%0d, want all 0",
                     bus.ram_data, bus.WR_channel, busy, cur_chan, drop_count);
        end
        checks++;
        if (exp_wr.size() != 0) begin
            fails++;
            $display("FAIL midreset_pending: got %0d writes outstanding, want 0", exp_wr.size());
        end
        exp_wr.delete();
        repeat (2) @(posedge txclk);
        #1;
        reset = 1'b1;
        idle(3);
        w1 = n_wr[1]; d1 = n_done[1];
        send_pkt(1, 0);
        idle(3);
        checks++;
        if (n_done[0] != d0 || n_wr[1] - w1 != PKT || n_done[1] - d1 != 1 || stream_bad != 0) begin
            fails++;
            $display("FAIL resync: got stale commits=%0d writes=%0d commits=%0d errors=%0d (%s), want 0 %0d 1 0",
                     n_done[0] - d0, n_wr[1] - w1, n_done[1] - d1, stream_bad, bad_msg, PKT);
        end
    endtask

    task automatic test_back_to_back();
        int w0, w2, d0, d2;
        checks++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL ovr_idle: got %b, want 0", overrun);
        end
        w0 = n_wr[0]; w2 = n_wr[2]; d0 = n_done[0]; d2 = n_done[2];
        send_pkt(0, 0);
        send_pkt(31, 0);
        idle(3);
        checks++;
        if (n_wr[0] - w0 != PKT || n_wr[2] - w2 != PKT || n_done[0] - d0 != 1 || n_done[2] - d2 != 1 || stream_bad != 0) begin
            fails++;
            $display("FAIL b2b_stream: got w0=%0d w2=%0d c0=%0d c2=%0d errors=%0d (%s), want %0d %0d 1 1 0",
                     n_wr[0] - w0, n_wr[2] - w2, n_done[0] - d0, n_done[2] - d2, stream_bad, bad_msg, PKT, PKT);
        end
        checks++;
        if (overrun !== 1'(ovr_m)) begin
            fails++;
            $display("FAIL b2b_overrun: got %b, want %b", overrun, ovr_m);
        end
        drive(1'b0, 32'h0, 1'b1);
        checks++;
        if (overrun !== 1'(ovr_m)) begin
            fails++;
            $display("FAIL ovr_clear: got %b, want %b", overrun, ovr_m);
        end
        repeat (5) send_pkt(9, 0);
        idle(2);
        checks++;
        if (drop_count !== 16'(drops) || drop_count2 !== 2'(sat2(drops))) begin
            fails++;
            $display("FAIL drop_sat: got cnt=%0d cnt2=%0d, want %0d %0d", drop_count, drop_count2, drops, sat2(drops));
        end
        drive(1'b1, hdr_word(9), 1'b0);
        send_body(PKT - 2, 0);
        drive(1'b1, $urandom, 1'b1);
        checks++;
        if (drop_count !== 16'(drops) || drop_count2 !== 2'(sat2(drops)) || dropped !== 1'b1) begin
            fails++;
            $display("FAIL clear_with_drop: got cnt=%0d cnt2=%0d pulse=%b, want %0d %0d 1",
                     drop_count, drop_count2, dropped, drops, sat2(drops));
        end
        idle(3);
        checks++;
        if (stream_bad != 0 || exp_wr.size() != 0 || exp_done.size() != 0 || exp_drop.size() != 0) begin
            fails++;
            $display("FAIL final_stream: got %0d errors (%s) pending wr=%0d done=%0d drop=%0d, want 0",
                     stream_bad, bad_msg, exp_wr.size(), exp_done.size(), exp_drop.size());
        end
    endtask

    initial begin
        test_reset();
        test_fwd_chan1();
        test_cmd();
        test_invalid_drop();
        test_space();
        test_gaps_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tx_packet_router.md
Name: tx_packet_router

Overview:
- Parametrised successor to the fixed two-way TX channel demultiplexer.
- Sits between tx_packer and the per-channel channel_ram instances inside the inband TX buffer.
- Takes the 32-bit packed USB word stream, decodes the channel field from each packet header and writes the whole packet to the matching channel RAM or to the command RAM.
- Drops packets whose channel is invalid or whose RAM has no space, and counts every drop. The fixed design had neither drop handling nor drop counting.

Parameters:
NUM_CHAN, 2, number of data channels (1..31); command RAM is index NUM_CHAN
PKT_WORDS, 128, 32-bit words per USB packet, power of two, >=4
CMD_CHAN_ID, 5'h1F, header channel code routed to the command RAM
CNT_W, 16, width of drop counter

Ports:
txclk  in  1  single clock for all logic
reset  in  1  asynchronous, active-low reset
usbdata_final  in  32  packed word from tx_packer
WR_final  in  1  word valid strobe, one word per asserted cycle
chan_have_space  in  NUM_CHAN+1  per-RAM "one full packet fits" flag
clear_status  in  1  synchronous clear of drop_count and overrun
ram_data  out  32  registered word to all channel RAMs
WR_channel  out  NUM_CHAN+1  one-hot write enable, aligned with ram_data
WR_done_channel  out  NUM_CHAN+1  one-cycle packet-commit pulse
busy  out  1  high while inside a packet (FWD or DROP)
cur_chan  out  5  channel code of the packet in progress
dropped  out  1  one-cycle pulse on each dropped packet
drop_count  out  CNT_W  saturating count of dropped packets
overrun  out  1  sticky: header arrived while the previous commit was pending

Behaviour:
- Asynchronous reset (reset=0):
  - state=IDLE, word counter=0.
  - All outputs 0, including ram_data, WR_channel, WR_done_channel, drop_count and overrun.
- Header decode: chan = usbdata_final[20:16].
  - dest = chan if chan < NUM_CHAN.
  - dest = NUM_CHAN if chan == CMD_CHAN_ID.
  - Any other value is invalid.
- States:
  - IDLE: on WR_final the word is the header. If dest is valid and chan_have_space[dest]=1, go to FWD; otherwise go to DROP.
    - Word counter is set to 1.
    - cur_chan latches chan.
  - FWD: every WR_final cycle produces the following on the next cycle:
    - ram_data = the word;
    - WR_channel = one-hot(dest).
    - The header itself is also written, one cycle after its arrival.
    - Counter increments. When the word numbered PKT_WORDS-1 is accepted, go to COMMIT.
  - DROP: consume words with no writes. When word PKT_WORDS-1 is accepted, pulse dropped, increment drop_count, return to IDLE.
  - COMMIT: lasts exactly one cycle. WR_done_channel[dest]=1, which is the cycle after the last WR_channel pulse. Return to IDLE.
- Latency: fixed 1 cycle from WR_final to WR_channel. Gaps in WR_final are allowed anywhere, and the counter holds during gaps.
- chan_have_space is sampled only at the header. A later deassertion mid-packet is ignored, because channel_ram guarantees whole-packet space.
- A WR_final arriving in the COMMIT cycle is accepted as the next header and the packet is not lost.
  - The commit still pulses for the old dest.
  - overrun is set.
  - The FSM goes directly to FWD or DROP for the new packet.
- drop_count saturates at all-ones.
- clear_status and a drop in the same cycle leave drop_count=1. overrun is cleared by clear_status unless it is being set in that same cycle.
- A reset mid-packet discards the partial packet and issues no WR_done. The first word after reset is treated as a header (resync).
- At most one bit of WR_channel and of WR_done_channel is ever high.

Decomposition:
- Shared package tx_inband_pkg holds:
  - CMD_CHAN_ID;
  - header field positions (CHAN_LSB=16, CHAN_MSB=20);
  - default PKT_WORDS;
  - state encoding (IDLE, FWD, DROP, COMMIT).
- One natural sub-module: tx_route_decode, combinational. It maps chan and chan_have_space to dest index, valid and accept.
- Counters and FSM stay in the top module.

Test Plan:
1. NUM_CHAN=2, all space=1; header chan=1, 128 words back-to-back -> 128 pulses on WR_channel[1], ram_data equals input delayed by 1 cycle, WR_done_channel[1] exactly 1 cycle after the last write, drop_count=0.
2. Header chan=5'h1F -> all writes on WR_channel[2]; WR_done_channel[2] pulses once.
3. Header chan=3 (invalid), then a chan=7 header -> no writes, dropped pulses twice, drop_count=2; clear_status -> 0.
4. chan_have_space[0]=0 at header -> packet dropped. chan_have_space[0]=1 at header, then forced to 0 at word 10 -> all 128 words still written and committed.
5. Random WR_final gaps (50% duty) on a chan=0 packet -> exactly 128 writes, order preserved. Reset asserted at word 60 -> no WR_done, outputs 0; the next packet after reset is routed correctly.
6. Header of the next packet in the COMMIT cycle -> both packets fully written, both commits issued, overrun=1. With CNT_W=2, five drops -> drop_count=3.
